// File: rtl/sys_mem_ctrl_pkg.sv
// Shared definitions for the system-side memory responder: bus direction codes,
// burst geometry, default timing and the controller state encoding.
package sys_mem_ctrl_pkg;

    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;

    localparam int   WAITSTATE  = 2;
    localparam int   OFS        = 4;
    localparam int   BLK        = 1 << OFS;
    localparam int   MEM_AW_DEF = 12;
    localparam int   DW         = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_TURN = 2'd3
    } state_e;

endpackage

// File: rtl/sys_mem_ctrl_if.sv
// Sys* bus between the L1 cache (master) and the memory responder (slave).
interface sys_mem_ctrl_if;
    import sys_mem_ctrl_pkg::*;

    // SysStrobe is a level request sampled only while the responder is idle; its
    // companions are captured on that same edge. SysReady is a one-cycle strobe per
    // beat (data valid only while it is high); Busy spans acceptance to return to idle.
    logic          SysStrobe;
    logic          SysRW;
    logic [31:0]   SysAddress;
    logic [DW-1:0] SysData_in;
    logic [DW-1:0] SysData_out;
    logic          SysReady;
    logic          Busy;

    modport master (
        output SysStrobe, SysRW, SysAddress, SysData_in,
        input  SysData_out, SysReady, Busy
    );

    modport slave (
        input  SysStrobe, SysRW, SysAddress, SysData_in,
        output SysData_out, SysReady, Busy
    );

endinterface

// File: rtl/sys_mem_ctrl_mem_array.sv
// Backing-store word RAM: one shared address, synchronous write, asynchronous read.
module sys_mem_ctrl_mem_array
    import sys_mem_ctrl_pkg::*;
#(
    parameter int AW = MEM_AW_DEF
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    // Contents deliberately survive reset; only power-up leaves them undefined.
    logic [DW-1:0] mem_q [0:(1 << AW) - 1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sys_mem_ctrl.sv
// Memory responder behind the cache Sys* port: single-word write-through stores and
// wrapped line-fill bursts, with a programmable number of wait cycles before every beat.
module sys_mem_ctrl
    import sys_mem_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = WAITSTATE,
    parameter int BURST_LEN   = BLK,
    parameter int MEM_AW      = MEM_AW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    sys_mem_ctrl_if.slave sys,
    output state_e        dbg_state_o
);

    localparam bit             HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [1:0]     WAIT_LAST = 2'(WAIT_STATES - 1);
    localparam logic [OFS-1:0] BEAT_LAST = OFS'(BURST_LEN - 1);

    state_e            state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic [OFS-1:0]    beat_q, beat_d;
    logic              rw_q, rw_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic              mem_we;
    logic [MEM_AW-1:0] rd_addr;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_rdata;

    // Byte-lane bits and address bits above the store alias away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sys.SysAddress[31:MEM_AW+2], sys.SysAddress[1:0]};

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (sys.SysStrobe) begin
                    rw_d    = sys.SysRW;
                    addr_d  = sys.SysAddress[MEM_AW+1:2];
                    wdata_d = sys.SysData_in;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = HAS_WAIT ? ST_WAIT : ST_XFER;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_XFER;
                end else begin
                    wait_d  = wait_q + 2'd1;
                end
            end
            ST_XFER: begin
                if (rw_q == RW_READ) begin
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = ST_TURN;
                    end else begin
                        state_d = HAS_WAIT ? ST_WAIT : ST_XFER;
                    end
                end else begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The beat about to be presented is fetched on the edge that enters XFER, so the
    // line index and offset come from the next-state values; the offset wraps in-line.
    assign rd_addr  = {addr_d[MEM_AW-1:OFS], beat_d};
    assign mem_we   = (state_q == ST_XFER) && (rw_q == RW_WRITE);
    assign mem_addr = mem_we ? addr_q : rd_addr;

    always_comb begin
        rdata_d = rdata_q;
        if ((state_d == ST_XFER) && (rw_d == RW_READ)) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            rw_q    <= RW_WRITE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    sys_mem_ctrl_mem_array #(
        .AW (MEM_AW)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign sys.SysReady    = (state_q == ST_XFER);
    assign sys.Busy        = (state_q != ST_IDLE);
    assign sys.SysData_out = rdata_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Bench for sys_mem_ctrl: a 2-wait-state and a 0-wait-state instance share clock and
// reset; transactions are checked against a word-array model of the backing store.
module tb_sys_mem_ctrl;
    import sys_mem_ctrl_pkg::*;

    localparam int AWORDS = 4096;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        strobe_r = 1'b1;
    logic        rw_r     = 1'b0;
    logic        sel      = 1'b0;
    logic [31:0] addr_r   = 32'h0;
    logic [31:0] din_r    = 32'h0;

    sys_mem_ctrl_if if2 ();
    sys_mem_ctrl_if if0 ();

    assign if2.SysStrobe  = strobe_r & ~sel;
    assign if0.SysStrobe  = strobe_r & sel;
    assign if2.SysRW      = rw_r;
    assign if0.SysRW      = rw_r;
    assign if2.SysAddress = addr_r;
    assign if0.SysAddress = addr_r;
    assign if2.SysData_in = din_r;
    assign if0.SysData_in = din_r;

    state_e dbg2, dbg0;

    sys_mem_ctrl #(.WAIT_STATES(2), .BURST_LEN(16), .MEM_AW(12)) dut_w2 (
        .clock(clock), .reset(reset), .sys(if2), .dbg_state_o(dbg2));
    sys_mem_ctrl #(.WAIT_STATES(0), .BURST_LEN(16), .MEM_AW(12)) dut_w0 (
        .clock(clock), .reset(reset), .sys(if0), .dbg_state_o(dbg0));

    logic        rdy_s, busy_s;
    logic [31:0] dout_s;
    assign rdy_s  = sel ? if0.SysReady    : if2.SysReady;
    assign busy_s = sel ? if0.Busy        : if2.Busy;
    assign dout_s = sel ? if0.SysData_out : if2.SysData_out;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model2 [AWORDS];
    logic [31:0] model0 [AWORDS];
    logic [31:0] last_exp [2];
    logic [31:0] got_q [$];
    int          rdyk_q [$];
    logic [31:0] exp_q [$];
    int          busy_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % AWORDS);
    endfunction

    function automatic logic [31:0] mget(input bit s, input int i);
        return s ? model0[i] : model2[i];
    endfunction

    task automatic mset(input bit s, input int i, input logic [31:0] v);
        if (s) model0[i] = v;
        else   model2[i] = v;
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit perturb);
        int  nexp;
        bit  done;
        nexp = rw ? 16 : 1;
        got_q.delete();
        rdyk_q.delete();
        busy_len = -1;
        @(negedge clock);
        for (int i = 0; i < 300 && busy_s; i++) @(negedge clock);
        chk("start_idle", busy_s, 0);
        strobe_r = 1'b1;
        rw_r     = rw;
        addr_r   = addr;
        din_r    = wdata;
        @(posedge clock);
        #1;
        if (!perturb) strobe_r = 1'b0;
        done = 1'b0;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge clock);
            if (rdy_s) begin
                got_q.push_back(dout_s);
                rdyk_q.push_back(k);
            end
            if (!busy_s) begin
                busy_len = k - 1;
                done     = 1'b1;
            end else if (perturb) begin
                if (got_q.size() >= nexp && !rdy_s) begin
                    strobe_r = 1'b0;
                end else begin
                    rw_r   = 1'($urandom_range(0, 1));
                    addr_r = $urandom;
                    din_r  = $urandom;
                end
            end
        end
        strobe_r = 1'b0;
        chk("txn_done", done, 1);
    endtask

    task automatic check_txn(input bit rw, input logic [31:0] addr, input logic [31:0] wdata);
        int w, occ, nexp, base;
        logic [31:0] e;
        w    = sel ? 0 : 2;
        occ  = rw ? 16 * (w + 1) + 1 : w + 2;
        nexp = rw ? 16 : 1;
        chk("busy_cycles", busy_len, occ);
        chk("beat_count", got_q.size(), nexp);
        exp_q.delete();
        if (rw) begin
            base = widx(addr) - (widx(addr) % 16);
            for (int j = 0; j < 16; j++) exp_q.push_back(mget(sel, base + j));
            last_exp[sel] = exp_q[15];
        end else begin
            exp_q.push_back(last_exp[sel]);
            mset(sel, widx(addr), wdata);
        end
        for (int j = 0; j < nexp; j++) begin
            e = exp_q.pop_front();
            if (j < got_q.size()) begin
                chk("beat_data", got_q[j], e);
                chk("beat_cycle", rdyk_q[j], (w + 1) * (j + 1));
            end
        end
    endtask

    typedef struct {
        bit          which;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          perturb;
        int          exp_busy;
        int          chk_idx;
        logic [31:0] chk_val;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] a, d;
        bit          rw, p;
        int          cnt;

        tbl[0] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0,         1'b0, 49, 2,  32'h0000_0108};
        tbl[1] = '{1'b0, 1'b0, 32'h0000_0208, 32'hDEADBEEF,  1'b0, 4,  -1, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0200, 32'h0,         1'b0, 49, 2,  32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_4000, 32'h12345678,  1'b1, 4,  -1, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b0, 49, 0,  32'h12345678};
        tbl[5] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         1'b0, 49, 1,  32'h0000_0004};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0,         1'b0, 17, 15, 32'h5000_001F};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0044, 32'hCAFEF00D,  1'b0, 2,  -1, 32'h0};
        tbl[8] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0,         1'b0, 17, 1,  32'hCAFEF00D};

        // Reset held with the strobe asserted: nothing may start.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready_w2", if2.SysReady, 0);
        chk("rst_busy_w2", if2.Busy, 0);
        chk("rst_dout_w2", if2.SysData_out, 0);
        chk("rst_state_w2", dbg2, ST_IDLE);
        chk("rst_ready_w0", if0.SysReady, 0);
        chk("rst_busy_w0", if0.Busy, 0);
        chk("rst_dout_w0", if0.SysData_out, 0);
        last_exp[0] = 32'h0;
        last_exp[1] = 32'h0;

        reset = 1'b1;
        @(posedge clock);
        #1;
        strobe_r = 1'b0;
        @(negedge clock);
        chk("accept_after_reset", busy_s, 1);
        for (int i = 0; i < 20 && busy_s; i++) @(negedge clock);
        chk("idle_after_first", busy_s, 0);
        model2[0] = 32'h0;

        // Preload through the bus: mem[i] = i*4 on the slow instance, 0x5000_0000+i on the fast one.
        sel = 1'b0;
        for (int i = 0; i < 256; i++) begin
            run_txn(1'b0, 32'(i * 4), 32'(i * 4), 1'b0);
            check_txn(1'b0, 32'(i * 4), 32'(i * 4));
        end
        sel = 1'b1;
        for (int i = 0; i < 64; i++) begin
            run_txn(1'b0, 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b0);
            check_txn(1'b0, 32'(i * 4), 32'h5000_0000 + 32'(i));
        end

        // Directed vectors.
        for (int t = 0; t < 9; t++) begin
            sel = tbl[t].which;
            run_txn(tbl[t].rw, tbl[t].addr, tbl[t].wdata, tbl[t].perturb);
            check_txn(tbl[t].rw, tbl[t].addr, tbl[t].wdata);
            chk("tbl_busy", busy_len, tbl[t].exp_busy);
            if (tbl[t].chk_idx >= 0 && tbl[t].chk_idx < got_q.size())
                chk("tbl_beat", got_q[tbl[t].chk_idx], tbl[t].chk_val);
        end

        // Random traffic; upper address bits random to exercise aliasing.
        for (int n = 0; n < 40; n++) begin
            sel = 1'($urandom_range(0, 1));
            a   = $urandom;
            if (sel) a[13:8] = 6'b0;
            else     a[13:10] = 4'b0;
            rw  = 1'($urandom_range(0, 1));
            d   = $urandom;
            p   = 1'($urandom_range(0, 1));
            run_txn(rw, a, d, p);
            check_txn(rw, a, d);
        end

        // Reset in the middle of a line fill, after beat 5 is presented.
        sel = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 300 && busy_s; i++) @(negedge clock);
        strobe_r = 1'b1;
        rw_r     = 1'b1;
        addr_r   = 32'h0000_0100;
        din_r    = 32'h0;
        @(posedge clock);
        #1;
        strobe_r = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 6; k++) begin
            @(negedge clock);
            if (rdy_s) cnt++;
        end
        chk("midburst_beats_seen", cnt, 6);
        chk("midburst_beat5", dout_s, model2[64 + 5]);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ready", rdy_s, 0);
        chk("midrst_busy", busy_s, 0);
        chk("midrst_dout", dout_s, 0);
        last_exp[0] = 32'h0;
        last_exp[1] = 32'h0;
        @(negedge clock);
        reset = 1'b1;

        run_txn(1'b0, 32'h0, 32'hA5A5_0001, 1'b0);
        check_txn(1'b0, 32'h0, 32'hA5A5_0001);
        run_txn(1'b1, 32'h0, 32'h0, 1'b0);
        check_txn(1'b1, 32'h0, 32'h0);
        run_txn(1'b1, 32'h0000_0100, 32'h0, 1'b0);
        check_txn(1'b1, 32'h0000_0100, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
